// File: rtl/scan_row_rx_pkg.sv
// Shared constants, FSM encoding and row-increment helper for scan_row_rx.
// ROWS comes from `CHIP_RES_ROW; SCAN_ROW_RX_SEQCHK_EN enables the sequence check.
`ifndef CHIP_RES_ROW
`define CHIP_RES_ROW 768
`endif

package scan_row_rx_pkg;

    localparam int LINE_CLKS = 48;
    localparam int SCAN_LINE_CLKS = LINE_CLKS;
    localparam int ADDR_W = 10;
    localparam int MARK_W = 10;
    localparam int ROWS = `CHIP_RES_ROW;
    localparam int CNT_W = 16;
    localparam int FRAME_W = 40;

    localparam int DISP_LSB = 0;
    localparam int MARK0_LSB = 10;
    localparam int CLR_LSB = 20;
    localparam int MARK1_LSB = 30;
    localparam int TAIL_LSB = 40;

    localparam logic [5:0] SLOT_FIRST = 6'd1;
    localparam logic [5:0] SLOT_DATA_END = 6'(TAIL_LSB);
    localparam logic [5:0] SLOT_END = 6'(LINE_CLKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHIFT = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] row_inc(
        input logic [ADDR_W-1:0] a
    );
        if (a == ADDR_W'(ROWS - 1)) return '0;
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/scan_row_rx_seqchk.sv
// Display-row sequence checker: flags a line whose row is not prev+1 mod ROWS.
// Instantiated by scan_row_rx only when SCAN_ROW_RX_SEQCHK_EN is defined.
module scan_row_seqchk
    import scan_row_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              vld,
    input  logic [ADDR_W-1:0] addr,
    output logic              seq_err
);

    logic [ADDR_W-1:0] prev;
    logic              have_prev;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev      <= '0;
            have_prev <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            seq_err <= vld && have_prev && (addr != row_inc(prev));
            if (vld) begin
                prev      <= addr;
                have_prev <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_row_rx.sv
// Scan-line receiver: deframes 48-clock lines into display/clear row addresses.
// Optional SCAN_ROW_RX_SEQCHK_EN adds the display-row sequence check on seq_err.
module scan_row_rx
    import scan_row_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rstn_in,
    input  logic              col_start,
    input  logic              row_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              line_vld,
    output logic              mark_err,
    output logic              len_err,
    output logic              seq_err,
    output logic [CNT_W-1:0]  line_cnt
);

    state_t             state;
    state_t             state_d;
    logic [5:0]         slot;
    logic [5:0]         slot_d;
    logic [FRAME_W-1:0] sr;
    logic [FRAME_W-1:0] frame;
    logic               tail_flag;
    logic               at_end;
    logic               early;
    logic               data_done;
    logic               marks_ok;
    logic               line_vld_d;
    logic               mark_err_d;
    logic               len_err_d;

    // frame includes the bit arriving this edge so results register at E40
    assign frame = {row_data, sr[FRAME_W-1:1]};
    assign marks_ok = (&frame[MARK0_LSB +: MARK_W])
                    && (&frame[MARK1_LSB +: MARK_W]);
    assign at_end = (state == S_TAIL) && (slot == SLOT_END);
    assign early = !col_start
                 && ((state == S_SHIFT)
                     || ((state == S_TAIL) && !at_end));
    assign data_done = (state == S_SHIFT)
                     && (slot == SLOT_DATA_END) && col_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            slot  <= '0;
        end else begin
            state <= state_d;
            slot  <= slot_d;
        end
    end

    always_comb begin
        state_d = state;
        slot_d  = slot;
        if (!rstn_in) begin
            state_d = S_IDLE;
            slot_d  = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!col_start) begin
                        state_d = S_SHIFT;
                        slot_d  = SLOT_FIRST;
                    end
                end
                S_SHIFT: begin
                    if (!col_start) begin
                        slot_d = SLOT_FIRST;
                    end else begin
                        slot_d = slot + 6'd1;
                        if (slot == SLOT_DATA_END) state_d = S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (!col_start) begin
                        state_d = S_SHIFT;
                        slot_d  = SLOT_FIRST;
                    end else if (at_end) begin
                        state_d = S_IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot + 6'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        line_vld_d = rstn_in && data_done;
        mark_err_d = rstn_in
                   && ((data_done && !marks_ok)
                       || (at_end && !col_start && tail_flag));
        len_err_d  = rstn_in && early;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            tail_flag <= 1'b0;
            disp_addr <= '0;
            clr_addr  <= '0;
            line_vld  <= 1'b0;
            mark_err  <= 1'b0;
            len_err   <= 1'b0;
            line_cnt  <= '0;
        end else begin
            line_vld <= line_vld_d;
            mark_err <= mark_err_d;
            len_err  <= len_err_d;
            if (state == S_SHIFT) sr <= frame;
            // sticky over slots 41..47, cleared whenever not in the tail
            if (state != S_TAIL) begin
                tail_flag <= 1'b0;
            end else if (!at_end && row_data) begin
                tail_flag <= 1'b1;
            end
            if (line_vld_d) begin
                disp_addr <= frame[DISP_LSB +: ADDR_W];
                clr_addr  <= frame[CLR_LSB +: ADDR_W];
                line_cnt  <= line_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SCAN_ROW_RX_SEQCHK_EN
    scan_row_seqchk u_seqchk (
        .clk     (clk),
        .rst     (rst),
        .clr     (!rstn_in),
        .vld     (line_vld_d),
        .addr    (frame[DISP_LSB +: ADDR_W]),
        .seq_err (seq_err)
    );
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_row_rx.sv
// Self-checking bench for scan_row_rx: scoreboard of expected lines
// popped on each line_vld, plus per-scenario error-pulse checks.
module tb_scan_row_rx;
    import scan_row_rx_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              rstn_in;
    logic              col_start;
    logic              row_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] clr_addr;
    logic              line_vld;
    logic              mark_err;
    logic              len_err;
    logic              seq_err;
    logic [CNT_W-1:0]  line_cnt;

    typedef struct {
        logic [9:0] d;
        logic [9:0] c;
        logic       mk;
        logic       sq;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   len_seen = 0;
    int   tail_seen = 0;
    int   seq_seen = 0;
    int   prev = 0;
    bit   have_prev = 0;

    scan_row_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rstn_in   (rstn_in),
        .col_start (col_start),
        .row_data  (row_data),
        .disp_addr (disp_addr),
        .clr_addr  (clr_addr),
        .line_vld  (line_vld),
        .mark_err  (mark_err),
        .len_err   (len_err),
        .seq_err   (seq_err),
        .line_cnt  (line_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [46:0] mk(input logic [9:0] d, input logic [9:0] c);
        return {7'b0, 10'h3FF, c, 10'h3FF, d};
    endfunction

    exp_t me;
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (line_vld) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_line_vld: got disp %0h at cycle %0d, required no line", disp_addr, cyc);
            end else begin
                me = sb.pop_front();
                exp_cnt++;
                if (disp_addr !== me.d) begin
                    n_fail++;
                    $display("FAIL disp_addr: got %0h required %0h", disp_addr, me.d);
                end
                n_checks++;
                if (clr_addr !== me.c) begin
                    n_fail++;
                    $display("FAIL clr_addr: got %0h required %0h", clr_addr, me.c);
                end
                n_checks++;
                if (mark_err !== me.mk) begin
                    n_fail++;
                    $display("FAIL mark_err: got %0b required %0b", mark_err, me.mk);
                end
                n_checks++;
                if (seq_err !== me.sq) begin
                    n_fail++;
                    $display("FAIL seq_err: got %0b required %0b (disp %0h)", seq_err, me.sq, me.d);
                end
                n_checks++;
                if (cyc != me.cyc) begin
                    n_fail++;
                    $display("FAIL vld_latency: got cycle %0d required %0d", cyc, me.cyc);
                end
                n_checks++;
                if (line_cnt !== CNT_W'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL line_cnt: got %0d required %0d", line_cnt, exp_cnt);
                end
            end
            if (seq_err) seq_seen++;
        end else begin
            if (mark_err) tail_seen++;
            if (seq_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_seq_err: got 1 required 0 at cycle %0d", cyc);
            end
        end
        if (len_err) len_seen++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            col_start = 1'b1;
            row_data = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [46:0] f, input int nslots, input bit push);
        exp_t e;
        for (int k = 0; k < nslots; k++) begin
            @(negedge clk);
            col_start = (k == 0) ? 1'b0 : 1'b1;
            row_data = (k == 0) ? 1'b0 : f[k-1];
            if (k == 0 && push) begin
                e.d = f[9:0];
                e.c = f[29:20];
                e.mk = !((&f[19:10]) && (&f[39:30]));
`ifdef SCAN_ROW_RX_SEQCHK_EN
                e.sq = have_prev && (int'(f[9:0]) != ((prev == ROWS - 1) ? 0 : prev + 1));
`else
                e.sq = 1'b0;
`endif
                prev = int'(f[9:0]);
                have_prev = 1'b1;
                e.cyc = cyc + 41;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drop_rstn(input int n);
        @(negedge clk);
        rstn_in = 1'b0;
        col_start = 1'b1;
        have_prev = 1'b0;
        repeat (n) @(negedge clk);
        rstn_in = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        if (disp_addr !== '0 || clr_addr !== '0) begin
            n_fail++;
            $display("FAIL %s_addr: got %0h/%0h required 0/0", tag, disp_addr, clr_addr);
        end
        n_checks++;
        if (line_vld !== 1'b0 || mark_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_vld_mark: got %0b/%0b required 0/0", tag, line_vld, mark_err);
        end
        n_checks++;
        if (len_err !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_len_seq: got %0b/%0b required 0/0", tag, len_err, seq_err);
        end
        n_checks++;
        if (line_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s_line_cnt: got %0d required 0", tag, line_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        rstn_in = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int l0 = len_seen;
        int t0 = tail_seen;
        int c0 = exp_cnt;
        for (int i = 0; i < 3; i++) send_frame(mk(10'h005, 10'h3FE), 48, 1);
        idle(4);
        n_checks++;
        if (len_seen != l0 || tail_seen != t0) begin
            n_fail++;
            $display("FAIL b2b_errors: got len %0d tail %0d required 0 0", len_seen - l0, tail_seen - t0);
        end
        n_checks++;
        if (line_cnt !== CNT_W'(c0 + 3) || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pending %0d required %0d pending 0", line_cnt, sb.size(), c0 + 3);
        end
    endtask

    task automatic test_marker_error();
        logic [46:0] f = mk(10'h009, 10'h00A);
        f[15] = 1'b0;
        send_frame(f, 48, 1);
        send_frame(mk(10'h00A, 10'h00B), 48, 1);
        idle(4);
        n_checks++;
        if (sb.size() != 0 || disp_addr !== 10'h00A) begin
            n_fail++;
            $display("FAIL marker_follow: got disp %0h pending %0d required 00a pending 0", disp_addr, sb.size());
        end
    endtask

    task automatic test_tail_error();
        int t0 = tail_seen;
        logic [46:0] f = mk(10'h020, 10'h021);
        f[43] = 1'b1;
        send_frame(f, 48, 1);
        send_frame(mk(10'h021, 10'h022), 48, 1);
        idle(4);
        n_checks++;
        if (tail_seen != t0 + 1) begin
            n_fail++;
            $display("FAIL tail_b2b: got %0d tail pulses required 1", tail_seen - t0);
        end
        send_frame(f, 48, 1);
        idle(4);
        n_checks++;
        if (tail_seen != t0 + 1) begin
            n_fail++;
            $display("FAIL tail_end_scan: got %0d tail pulses required 1", tail_seen - t0);
        end
    endtask

    task automatic test_early_start();
        int l0 = len_seen;
        int c0 = exp_cnt;
        send_frame(mk(10'h030, 10'h130), 30, 0);
        send_frame(mk(10'h031, 10'h131), 48, 1);
        idle(4);
        n_checks++;
        if (len_seen != l0 + 1 || line_cnt !== CNT_W'(c0 + 1)) begin
            n_fail++;
            $display("FAIL early30: got len %0d cnt %0d required len 1 cnt %0d", len_seen - l0, line_cnt, c0 + 1);
        end
        n_checks++;
        if (disp_addr !== 10'h031 || clr_addr !== 10'h131) begin
            n_fail++;
            $display("FAIL early30_addr: got %0h/%0h required 031/131", disp_addr, clr_addr);
        end
        send_frame(mk(10'h032, 10'h132), 40, 0);
        send_frame(mk(10'h033, 10'h133), 48, 1);
        idle(4);
        n_checks++;
        if (len_seen != l0 + 2 || line_cnt !== CNT_W'(c0 + 2)) begin
            n_fail++;
            $display("FAIL early40: got len %0d cnt %0d required len 2 cnt %0d", len_seen - l0, line_cnt, c0 + 2);
        end
    endtask

    task automatic test_rstn_abort();
        int l0 = len_seen;
        int t0 = tail_seen;
        send_frame(mk(10'h040, 10'h140), 12, 0);
        drop_rstn(3);
        idle(2);
        send_frame(mk(10'h055, 10'h155), 48, 1);
        idle(4);
        n_checks++;
        if (len_seen != l0 || tail_seen != t0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rstn_abort: got len %0d tail %0d pending %0d required 0 0 0", len_seen - l0, tail_seen - t0, sb.size());
        end
        n_checks++;
        if (disp_addr !== 10'h055) begin
            n_fail++;
            $display("FAIL rstn_abort_addr: got %0h required 055", disp_addr);
        end
    endtask

    task automatic test_sequence();
        int s0 = seq_seen;
        int want;
        drop_rstn(2);
        idle(2);
        send_frame(mk(10'(ROWS - 2), 10'h001), 48, 1);
        send_frame(mk(10'(ROWS - 1), 10'h002), 48, 1);
        send_frame(mk(10'h000, 10'h003), 48, 1);
        send_frame(mk(10'h002, 10'h004), 48, 1);
        idle(4);
`ifdef SCAN_ROW_RX_SEQCHK_EN
        want = 1;
`else
        want = 0;
`endif
        n_checks++;
        if (seq_seen - s0 != want) begin
            n_fail++;
            $display("FAIL seq_count: got %0d seq pulses required %0d", seq_seen - s0, want);
        end
    endtask

    task automatic test_mid_reset();
        n_checks++;
        if (line_cnt === '0) begin
            n_fail++;
            $display("FAIL pre_reset_cnt: got 0 required nonzero");
        end
        send_frame(mk(10'h060, 10'h160), 20, 0);
        @(negedge clk);
        rst = 1'b1;
        col_start = 1'b1;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        have_prev = 1'b0;
        idle(1);
        send_frame(mk(10'h061, 10'h162), 48, 1);
        idle(4);
        n_checks++;
        if (line_cnt !== CNT_W'(1) || disp_addr !== 10'h061 || clr_addr !== 10'h162) begin
            n_fail++;
            $display("FAIL post_reset_line: got cnt %0d %0h/%0h required 1 061/162", line_cnt, disp_addr, clr_addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        rstn_in = 1'b0;
        col_start = 1'b1;
        row_data = 1'b0;
        test_reset();
        test_back_to_back();
        test_marker_error();
        test_tail_error();
        test_early_start();
        test_rstn_abort();
        test_sequence();
        test_mid_reset();
        idle(5);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_lines: got %0d lines never seen required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
